// File: rtl/mlaccel_mem_arbiter_if.sv
// mlaccel_mem_arbiter_if
//   Bundles the requester-side and memory-side signals of the main memory
//   arbiter so that one connection carries the whole bus.
// Signals
//   c_ren/c_wen/c_addr/c_wdata   compute command (fire-and-forget)
//   c_stall/c_rdata              compute back-pressure and raw memory data
//   q_valid/q_ready/q_wen/q_addr/q_wdata/q_rvalid/q_rdata   host port
//   s_valid/s_ready/s_addr/s_rvalid/s_rdata                 sequencer port
//   mem_addr/mem_wen/mem_wdata/mem_rdata                    single-port memory
// Modports
//   slave  : the arbiter itself
//   master : the environment (requesters plus memory)
interface mlaccel_mem_arbiter_if;
  logic        c_ren;
  logic [7:0]  c_wen;
  logic [15:0] c_addr;
  logic [63:0] c_wdata;
  logic        c_stall;
  logic [63:0] c_rdata;

  logic        q_valid;
  logic        q_ready;
  logic [7:0]  q_wen;
  logic [15:0] q_addr;
  logic [63:0] q_wdata;
  logic        q_rvalid;
  logic [63:0] q_rdata;

  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_addr;
  logic        s_rvalid;
  logic [63:0] s_rdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wen;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  c_ren, c_wen, c_addr, c_wdata,
    output c_stall, c_rdata,
    input  q_valid, q_wen, q_addr, q_wdata,
    output q_ready, q_rvalid, q_rdata,
    input  s_valid, s_addr,
    output s_ready, s_rvalid, s_rdata,
    output mem_addr, mem_wen, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_ren, c_wen, c_addr, c_wdata,
    input  c_stall, c_rdata,
    output q_valid, q_wen, q_addr, q_wdata,
    input  q_ready, q_rvalid, q_rdata,
    output s_valid, s_addr,
    input  s_ready, s_rvalid, s_rdata,
    input  mem_addr, mem_wen, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mlaccel_mem_arbiter.sv
// mlaccel_mem_arbiter
//   Shares the single-port 64-bit main memory between compute (highest
//   priority, no handshake), the host QPI port and the sequencer fetch port.
//   The winning command is registered onto the memory bus; host/sequencer
//   completions come back exactly RD_LAT cycles after their grant. Host and
//   sequencer wait time is bounded by stalling compute once either has waited
//   STARVE_LIMIT cycles (0 disables the stall).
// Ports
//   clock  in  clock
//   reset  in  synchronous active-high reset
//   bus    mlaccel_mem_arbiter_if.slave (requester ports and memory port)
module mlaccel_mem_arbiter #(
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  mlaccel_mem_arbiter_if.slave        bus
);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_C    = 2'd1;
  localparam logic [1:0] GNT_Q    = 2'd2;
  localparam logic [1:0] GNT_S    = 2'd3;

  // Limits above 255 can never be reached by the 8-bit counters; clamping to
  // 256 keeps the compare in 9 bits and makes such limits behave as "never".
  localparam bit         STARVE_EN = (STARVE_LIMIT != 0);
  localparam logic [8:0] LIMIT     = (STARVE_LIMIT > 256) ? 9'd256 : 9'(STARVE_LIMIT);

  logic [1:0]        grant;
  logic              c_req, q_avail, s_avail;
  logic              q_starved, s_starved;
  logic              q_grant, s_grant;
  logic              q_busy, s_busy;
  logic [7:0]        q_wait, s_wait;
  logic              c_stall_r;
  logic [RD_LAT-1:0] q_pipe, s_pipe;
  logic [15:0]       mem_addr_r;
  logic [7:0]        mem_wen_r;
  logic [63:0]       mem_wdata_r;

  assign c_req     = bus.c_ren || (|bus.c_wen);
  assign q_avail   = bus.q_valid && !q_busy;
  assign s_avail   = bus.s_valid && !s_busy;
  assign q_starved = STARVE_EN && ({1'b0, q_wait} >= LIMIT);
  assign s_starved = STARVE_EN && ({1'b0, s_wait} >= LIMIT);

  // Compute wins unless stalled. While stalled, a starved client jumps ahead
  // of a merely waiting one so the stall ends as soon as possible.
  always_comb begin
    grant = GNT_NONE;
    if (!c_stall_r && c_req)
      grant = GNT_C;
    else if (c_stall_r && q_starved && q_avail)
      grant = GNT_Q;
    else if (c_stall_r && s_starved && s_avail)
      grant = GNT_S;
    else if (q_avail)
      grant = GNT_Q;
    else if (s_avail)
      grant = GNT_S;
  end

  assign q_grant = (grant == GNT_Q);
  assign s_grant = (grant == GNT_S);

  // Register the winner onto the memory bus; address/data hold when idle so
  // only the byte enables have to be forced quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr_r  <= '0;
      mem_wen_r   <= '0;
      mem_wdata_r <= '0;
    end else begin
      mem_wen_r <= '0;
      case (grant)
        GNT_C: begin
          mem_addr_r  <= bus.c_addr;
          mem_wen_r   <= bus.c_wen;
          mem_wdata_r <= bus.c_wdata;
        end
        GNT_Q: begin
          mem_addr_r  <= bus.q_addr;
          mem_wen_r   <= bus.q_wen;
          mem_wdata_r <= bus.q_wdata;
        end
        GNT_S: mem_addr_r <= bus.s_addr;
        default: ;
      endcase
    end
  end

  // Completion pipes: bit 0 is set the cycle after grant, so the top bit
  // fires exactly RD_LAT cycles after the grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_pipe <= '0;
      s_pipe <= '0;
    end else begin
      q_pipe <= {q_pipe[RD_LAT-2:0], q_grant};
      s_pipe <= {s_pipe[RD_LAT-2:0], s_grant};
    end
  end

  // One outstanding request per host/sequencer port.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_busy <= 1'b0;
      s_busy <= 1'b0;
    end else begin
      if (q_grant)
        q_busy <= 1'b1;
      else if (q_pipe[RD_LAT-1])
        q_busy <= 1'b0;
      if (s_grant)
        s_busy <= 1'b1;
      else if (s_pipe[RD_LAT-1])
        s_busy <= 1'b0;
    end
  end

  // Wait counters only run while a client could be served but is not.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_wait <= '0;
      s_wait <= '0;
    end else begin
      if (q_grant)
        q_wait <= '0;
      else if (q_avail && q_wait != 8'hFF)
        q_wait <= q_wait + 8'd1;
      if (s_grant)
        s_wait <= '0;
      else if (s_avail && s_wait != 8'hFF)
        s_wait <= s_wait + 8'd1;
    end
  end

  // A starved client being granted this cycle releases the stall next cycle.
  always_ff @(posedge clock) begin
    if (reset)
      c_stall_r <= 1'b0;
    else
      c_stall_r <= STARVE_EN && ((q_starved && !q_grant) || (s_starved && !s_grant));
  end

  assign bus.c_stall   = c_stall_r;
  assign bus.c_rdata   = bus.mem_rdata;
  assign bus.q_ready   = q_grant;
  assign bus.q_rvalid  = q_pipe[RD_LAT-1];
  assign bus.q_rdata   = bus.mem_rdata;
  assign bus.s_ready   = s_grant;
  assign bus.s_rvalid  = s_pipe[RD_LAT-1];
  assign bus.s_rdata   = bus.mem_rdata;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wen   = mem_wen_r;
  assign bus.mem_wdata = mem_wdata_r;

  c_access_during_stall: assert property (
    @(posedge clock) disable iff (reset) bus.c_stall |-> !(bus.c_ren || (|bus.c_wen)));

endmodule

// File: tb/tb_mlaccel_mem_arbiter.sv
// tb_mlaccel_mem_arbiter
//   Directed bench for the memory arbiter: a byte-enabled memory behind the
//   arbiter, a transaction-level reference model compared every cycle, and
//   literal expectations for the documented scenarios.
module tb_mlaccel_mem_arbiter;
  localparam int RD_LAT       = 2;
  localparam int STARVE_LIMIT = 32;

  logic clock = 1'b0;
  logic reset;
  int   pass_count  = 0;
  int   check_count = 0;
  int   cycle_cnt   = 0;

  mlaccel_mem_arbiter_if bus ();

  mlaccel_mem_arbiter #(
    .RD_LAT       (RD_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle_cnt);
  endtask

  // Memory behind the arbiter: read-first, one cycle read latency.
  logic [63:0] mem_store [logic [15:0]];
  always @(posedge clock) begin
    logic [63:0] cur;
    if (!reset) begin
      cur = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr] : 64'd0;
      bus.mem_rdata <= cur;
      if (bus.mem_wen != 8'd0) begin
        for (int b = 0; b < 8; b++)
          if (bus.mem_wen[b]) cur[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
        mem_store[bus.mem_addr] = cur;
      end
    end
  end

  // Reference model: what memory should hold, who owns the bus each cycle,
  // and when each outstanding completion is due.
  logic [63:0] exp_mem [logic [15:0]];
  bit          model_valid = 1'b0;
  logic [15:0] m_addr;
  logic [7:0]  m_wen;
  logic [63:0] m_wdata;
  bit          m_stall, m_q_busy, m_s_busy, m_q_write;
  int          m_q_wait, m_s_wait, m_q_due, m_s_due;
  logic [63:0] m_q_data, m_s_data;

  function automatic logic [63:0] expRead(input logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 64'd0;
  endfunction

  function automatic void expWrite(input logic [15:0] a, input logic [7:0] wen, input logic [63:0] d);
    logic [63:0] cur;
    cur = expRead(a);
    for (int b = 0; b < 8; b++)
      if (wen[b]) cur[b*8 +: 8] = d[b*8 +: 8];
    exp_mem[a] = cur;
  endfunction

  always @(negedge clock) begin
    int win;
    bit c_req, q_av, s_av, q_st, s_st, next_stall;
    if (model_valid) begin
      checkOutput("mem_addr",  bus.mem_addr,  m_addr);
      checkOutput("mem_wen",   bus.mem_wen,   m_wen);
      checkOutput("mem_wdata", bus.mem_wdata, m_wdata);
      checkOutput("c_stall",   bus.c_stall,   m_stall);
      checkOutput("q_rvalid",  bus.q_rvalid,  (m_q_due == cycle_cnt));
      checkOutput("s_rvalid",  bus.s_rvalid,  (m_s_due == cycle_cnt));
      if (m_q_due == cycle_cnt && !m_q_write)
        checkOutput("q_rdata", bus.q_rdata, m_q_data);
      if (m_s_due == cycle_cnt)
        checkOutput("s_rdata", bus.s_rdata, m_s_data);
    end
    if (reset) begin
      model_valid = 1'b1;
      m_addr = '0; m_wen = '0; m_wdata = '0;
      m_stall = 0; m_q_busy = 0; m_s_busy = 0; m_q_write = 0;
      m_q_wait = 0; m_s_wait = 0; m_q_due = -1; m_s_due = -1;
    end else begin
      c_req = bus.c_ren || (bus.c_wen != 8'd0);
      q_av  = bus.q_valid && !m_q_busy;
      s_av  = bus.s_valid && !m_s_busy;
      q_st  = (STARVE_LIMIT != 0) && (m_q_wait >= STARVE_LIMIT);
      s_st  = (STARVE_LIMIT != 0) && (m_s_wait >= STARVE_LIMIT);
      if (!m_stall && c_req)         win = 1;
      else if (m_stall && q_st && q_av) win = 2;
      else if (m_stall && s_st && s_av) win = 3;
      else if (q_av)                 win = 2;
      else if (s_av)                 win = 3;
      else                           win = 0;
      checkOutput("q_ready", bus.q_ready, (win == 2));
      checkOutput("s_ready", bus.s_ready, (win == 3));

      if (m_q_due == cycle_cnt) begin m_q_busy = 0; m_q_due = -1; end
      if (m_s_due == cycle_cnt) begin m_s_busy = 0; m_s_due = -1; end
      next_stall = (q_st && win != 2) || (s_st && win != 3);
      if (win == 2) m_q_wait = 0;
      else if (q_av) m_q_wait = (m_q_wait < 255) ? m_q_wait + 1 : 255;
      if (win == 3) m_s_wait = 0;
      else if (s_av) m_s_wait = (m_s_wait < 255) ? m_s_wait + 1 : 255;
      m_wen = '0;
      case (win)
        1: begin
          m_addr = bus.c_addr; m_wen = bus.c_wen; m_wdata = bus.c_wdata;
          expWrite(bus.c_addr, bus.c_wen, bus.c_wdata);
        end
        2: begin
          m_addr = bus.q_addr; m_wen = bus.q_wen; m_wdata = bus.q_wdata;
          m_q_busy = 1; m_q_due = cycle_cnt + RD_LAT;
          m_q_write = (bus.q_wen != 8'd0);
          m_q_data = expRead(bus.q_addr);
          expWrite(bus.q_addr, bus.q_wen, bus.q_wdata);
        end
        3: begin
          m_addr = bus.s_addr;
          m_s_busy = 1; m_s_due = cycle_cnt + RD_LAT;
          m_s_data = expRead(bus.s_addr);
        end
        default: ;
      endcase
      m_stall = next_stall;
    end
  end

  task automatic applyStimulus(input logic ren, input logic [7:0] wen, input logic [15:0] addr,
                               input logic [63:0] wdata);
    bus.c_ren = ren; bus.c_wen = wen; bus.c_addr = addr; bus.c_wdata = wdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic atCycle(input int c);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (cycle_cnt >= c) return;
    end
    check_count++;
    $display("[TB] FAIL at_cycle_timeout: waited for cycle %0d, now %0d", c, cycle_cnt);
  endtask

  // Caller sits just after a rising edge; returns just after the edge that
  // follows the grant, with q_valid already dropped.
  task automatic issueQ(input logic [7:0] wen, input logic [15:0] addr, input logic [63:0] wdata,
                        output int gcyc);
    gcyc = -1;
    bus.q_wen = wen; bus.q_addr = addr; bus.q_wdata = wdata; bus.q_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.q_ready) begin gcyc = cycle_cnt; break; end
      @(posedge clock); #1;
    end
    if (gcyc < 0) begin
      check_count++;
      $display("[TB] FAIL q_grant_timeout: got no q_ready, expected one within 100 cycles");
    end
    @(posedge clock); #1;
    bus.q_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected one before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, t0, g, stall_at;
    applyStimulus(1'b0, 8'd0, 16'd0, 64'd0);
    bus.q_valid = 0; bus.q_wen = 0; bus.q_addr = 0; bus.q_wdata = 0;
    bus.s_valid = 0; bus.s_addr = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    checkOutput("rst_mem_wen",  bus.mem_wen,  8'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 16'd0);
    checkOutput("rst_c_stall",  bus.c_stall,  1'b0);
    checkOutput("rst_q_rvalid", bus.q_rvalid, 1'b0);
    @(posedge clock); #1;

    $display("[TB] compute reads 0x0010 back to back");
    applyStimulus(1'b1, 8'd0, 16'h0010, 64'd0);
    @(posedge clock); #1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("c_read_addr",  bus.mem_addr, 16'h0010);
      checkOutput("c_read_wen",   bus.mem_wen,  8'd0);
      checkOutput("c_read_stall", bus.c_stall,  1'b0);
      checkOutput("c_read_qrdy",  bus.q_ready,  1'b0);
      checkOutput("c_read_srdy",  bus.s_ready,  1'b0);
      @(posedge clock); #1;
    end
    applyStimulus(1'b1, 8'h0F, 16'h0020, 64'hAABB_CCDD_EEFF_0011);
    @(posedge clock); #1;
    applyStimulus(1'b0, 8'd0, 16'd0, 64'd0);
    @(negedge clock);
    checkOutput("c_write_wen",  bus.mem_wen,  8'h0F);
    checkOutput("c_write_addr", bus.mem_addr, 16'h0020);
    @(posedge clock); #1;

    $display("[TB] host write then read back");
    issueQ(8'hFF, 16'h0100, 64'h1122_3344_5566_7788, t);
    atCycle(t + 1);
    checkOutput("q_wr_mem_wen",   bus.mem_wen,   8'hFF);
    checkOutput("q_wr_mem_addr",  bus.mem_addr,  16'h0100);
    checkOutput("q_wr_mem_wdata", bus.mem_wdata, 64'h1122_3344_5566_7788);
    checkOutput("q_wr_early_rv",  bus.q_rvalid,  1'b0);
    atCycle(t + 2);
    checkOutput("q_wr_rvalid", bus.q_rvalid, 1'b1);
    @(posedge clock); #1;
    issueQ(8'h00, 16'h0100, 64'd0, t);
    atCycle(t + 2);
    checkOutput("q_rd_rvalid", bus.q_rvalid, 1'b1);
    checkOutput("q_rd_rdata",  bus.q_rdata,  64'h1122_3344_5566_7788);
    @(posedge clock); #1;
    issueQ(8'h00, 16'h0020, 64'd0, t);
    atCycle(t + 2);
    checkOutput("q_rd_partial", bus.q_rdata, 64'h0000_0000_EEFF_0011);
    @(posedge clock); #1;

    $display("[TB] host and sequencer request together");
    bus.q_valid = 1; bus.q_wen = 0; bus.q_addr = 16'h0020;
    bus.s_valid = 1; bus.s_addr = 16'h0100;
    @(negedge clock);
    t = cycle_cnt;
    checkOutput("qs_first_q", bus.q_ready, 1'b1);
    checkOutput("qs_first_s", bus.s_ready, 1'b0);
    @(posedge clock); #1;
    bus.q_valid = 0;
    @(negedge clock);
    checkOutput("qs_second_s", bus.s_ready, 1'b1);
    checkOutput("qs_second_q", bus.q_ready, 1'b0);
    @(posedge clock); #1;
    bus.s_valid = 0;
    atCycle(t + 2);
    checkOutput("qs_q_rvalid", bus.q_rvalid, 1'b1);
    checkOutput("qs_s_early",  bus.s_rvalid, 1'b0);
    atCycle(t + 3);
    checkOutput("qs_s_rvalid", bus.s_rvalid, 1'b1);
    checkOutput("qs_s_rdata",  bus.s_rdata,  64'h1122_3344_5566_7788);
    @(posedge clock); #1;
    idle(2);

    $display("[TB] compute saturates the memory while host waits");
    bus.q_valid = 1; bus.q_wen = 0; bus.q_addr = 16'h0100;
    applyStimulus(1'b1, 8'd0, 16'h0030, 64'd0);
    t0 = cycle_cnt; stall_at = -1; g = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.c_stall && stall_at < 0) stall_at = cycle_cnt;
      if (bus.q_ready) begin g = cycle_cnt; break; end
      @(posedge clock); #1;
      bus.c_ren = !bus.c_stall;
    end
    @(posedge clock); #1;
    bus.q_valid = 0;
    bus.c_ren = !bus.c_stall;
    checkOutput("starve_stall_at", 64'(stall_at - t0), 64'd33);
    checkOutput("starve_grant_at", 64'(g - t0),        64'd33);
    @(negedge clock);
    checkOutput("starve_release", bus.c_stall, 1'b0);
    @(posedge clock); #1;
    applyStimulus(1'b0, 8'd0, 16'd0, 64'd0);
    idle(3);

    $display("[TB] reset during an outstanding host read");
    issueQ(8'h00, 16'h0100, 64'd0, t);
    reset = 1'b1;
    atCycle(t + 2);
    checkOutput("rst_mid_rvalid",   bus.q_rvalid, 1'b0);
    checkOutput("rst_mid_mem_wen",  bus.mem_wen,  8'd0);
    checkOutput("rst_mid_mem_addr", bus.mem_addr, 16'd0);
    checkOutput("rst_mid_stall",    bus.c_stall,  1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    atCycle(t + 3);
    checkOutput("rst_mid_rvalid2", bus.q_rvalid, 1'b0);
    @(posedge clock); #1;
    bus.q_valid = 1; bus.q_wen = 0; bus.q_addr = 16'h0020;
    @(negedge clock);
    checkOutput("rst_mid_q_ready", bus.q_ready, 1'b1);
    @(posedge clock); #1;
    bus.q_valid = 0;
    idle(4);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
